// File: rtl/cv32e40p_x_if_pkg.sv
// Shared types for the core/coprocessor xmem interface and the data-port arbiter.
package cv32e40p_x_if_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mem_req_type_e;

  typedef enum logic {
    SRC_CORE = 1'b0,
    SRC_XMEM = 1'b1
  } arb_src_e;

  localparam logic [2:0] XMEM_W_BYTE = 3'd0;
  localparam logic [2:0] XMEM_W_HALF = 3'd1;
  localparam logic [2:0] XMEM_W_WORD = 3'd2;

endpackage

// File: rtl/cv32e40p_arb_fifo.sv
// Small synchronous FIFO with occupancy count; push is accepted when full if a pop happens in the same cycle.
module cv32e40p_arb_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    cnt_q;
  logic             full, do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full | do_pop);
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      if (do_pop)  rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/cv32e40p_xmem_data_arbiter.sv
// Round-robin arbiter sharing the OBI data port between the core LSU and the coprocessor xmem channel,
// with in-order response routing and a buffered xmem response path.
module cv32e40p_xmem_data_arbiter
  import cv32e40p_x_if_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned XMEM_RESP_DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,

  input  logic          core_req_i,
  output logic          core_gnt_o,
  input  logic [31:0]   core_addr_i,
  input  logic [31:0]   core_wdata_i,
  input  logic          core_we_i,
  input  logic [3:0]    core_be_i,
  output logic          core_rvalid_o,
  output logic [31:0]   core_rdata_o,

  input  logic          xmem_valid_i,
  output logic          xmem_ready_o,
  input  logic [31:0]   xmem_laddr_i,
  input  logic [31:0]   xmem_wdata_i,
  input  logic [2:0]    xmem_width_i,
  input  mem_req_type_e xmem_req_type_i,
  output logic          xmem_rvalid_o,
  input  logic          xmem_rready_i,
  output logic [31:0]   xmem_rdata_o,
  output logic [4:0]    xmem_range_o,
  output logic          xmem_status_o,

  output logic          mem_req_o,
  input  logic          mem_gnt_i,
  output logic [31:0]   mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  output logic          mem_we_o,
  output logic [3:0]    mem_be_o,
  input  logic          mem_rvalid_i,
  input  logic [31:0]   mem_rdata_i
);

  localparam int unsigned TCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned RCW = $clog2(XMEM_RESP_DEPTH + 1);

  arb_src_e       rr_pref_q, lock_src_q, sel;
  logic           lock_q;
  logic [TCW-1:0] xmem_inflight_q;

  logic           core_elig, xmem_elig, sel_elig, grant;
  logic [TCW-1:0] tag_cnt;
  logic [RCW-1:0] resp_cnt;
  logic [0:0]     tag_head;
  logic           tag_empty, tag_pop;
  logic           resp_empty, resp_push, resp_pop;
  logic [31:0]    resp_head;

  logic [3:0]     xmem_be;
  logic [31:0]    xmem_wd;

  // Capacity is judged on registered counts only; a pop in this cycle frees space for the next.
  assign core_elig = core_req_i & (32'(tag_cnt) < MAX_OUTSTANDING);
  assign xmem_elig = xmem_valid_i & (32'(tag_cnt) < MAX_OUTSTANDING) &
                     ((32'(resp_cnt) + 32'(xmem_inflight_q)) < XMEM_RESP_DEPTH);

  always_comb begin
    sel = SRC_CORE;
    if (lock_q)                       sel = lock_src_q;
    else if (core_elig && xmem_elig)  sel = rr_pref_q;
    else if (xmem_elig)               sel = SRC_XMEM;
  end

  assign sel_elig = (sel == SRC_CORE) ? core_elig : xmem_elig;

  always_comb begin
    xmem_be = 4'b1111;
    xmem_wd = xmem_wdata_i;
    case (xmem_width_i)
      XMEM_W_BYTE: begin
        xmem_be = 4'b0001 << xmem_laddr_i[1:0];
        xmem_wd = {4{xmem_wdata_i[7:0]}};
      end
      XMEM_W_HALF: begin
        xmem_be = 4'b0011 << xmem_laddr_i[1:0];
        xmem_wd = {2{xmem_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign mem_req_o    = sel_elig & ~rst_i;
  assign grant        = mem_req_o & mem_gnt_i;
  assign core_gnt_o   = grant & (sel == SRC_CORE);
  assign xmem_ready_o = grant & (sel == SRC_XMEM);

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    if (mem_req_o) begin
      if (sel == SRC_CORE) begin
        mem_addr_o  = core_addr_i;
        mem_wdata_o = core_wdata_i;
        mem_we_o    = core_we_i;
        mem_be_o    = core_be_i;
      end else begin
        mem_addr_o  = {xmem_laddr_i[31:2], 2'b00};
        mem_wdata_o = xmem_wd;
        mem_we_o    = (xmem_req_type_i == WRITE);
        mem_be_o    = xmem_be;
      end
    end
  end

  // Lock is simply "requesting but not granted"; it also drops if the locked requester withdraws.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_pref_q       <= SRC_CORE;
      lock_q          <= 1'b0;
      lock_src_q      <= SRC_CORE;
      xmem_inflight_q <= '0;
    end else begin
      lock_q     <= mem_req_o & ~mem_gnt_i;
      lock_src_q <= sel;
      if (grant) rr_pref_q <= (sel == SRC_CORE) ? SRC_XMEM : SRC_CORE;
      case ({xmem_ready_o, resp_push})
        2'b10:   xmem_inflight_q <= xmem_inflight_q + 1'b1;
        2'b01:   xmem_inflight_q <= xmem_inflight_q - 1'b1;
        default: xmem_inflight_q <= xmem_inflight_q;
      endcase
    end
  end

  cv32e40p_arb_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_OUTSTANDING)
  ) i_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (grant),
    .data_i  (sel),
    .pop_i   (tag_pop),
    .data_o  (tag_head),
    .count_o (tag_cnt),
    .empty_o (tag_empty)
  );

  assign tag_pop       = mem_rvalid_i & ~tag_empty;
  assign core_rvalid_o = tag_pop & (tag_head[0] == SRC_CORE);
  assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : '0;
  assign resp_push     = tag_pop & (tag_head[0] == SRC_XMEM);

  cv32e40p_arb_fifo #(
    .WIDTH (32),
    .DEPTH (XMEM_RESP_DEPTH)
  ) i_resp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (resp_push),
    .data_i  (mem_rdata_i),
    .pop_i   (resp_pop),
    .data_o  (resp_head),
    .count_o (resp_cnt),
    .empty_o (resp_empty)
  );

  assign xmem_rvalid_o = ~resp_empty;
  assign xmem_rdata_o  = xmem_rvalid_o ? resp_head : '0;
  assign resp_pop      = xmem_rvalid_o & xmem_rready_i;
  assign xmem_range_o  = '0;
  assign xmem_status_o = 1'b0;

  a_rvalid_has_owner: assert property (@(posedge clk_i) disable iff (rst_i) mem_rvalid_i |-> !tag_empty);

endmodule

// File: tb/tb_cv32e40p_xmem_data_arbiter.sv
// Directed self-checking bench for the xmem/core data-port arbiter.
module tb_cv32e40p_xmem_data_arbiter;
  import cv32e40p_x_if_pkg::*;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          core_req_i, core_we_i;
  logic [31:0]   core_addr_i, core_wdata_i;
  logic [3:0]    core_be_i;
  logic          core_gnt_o, core_rvalid_o;
  logic [31:0]   core_rdata_o;
  logic          xmem_valid_i, xmem_rready_i;
  logic [31:0]   xmem_laddr_i, xmem_wdata_i;
  logic [2:0]    xmem_width_i;
  mem_req_type_e xmem_req_type_i;
  logic          xmem_ready_o, xmem_rvalid_o, xmem_status_o;
  logic [31:0]   xmem_rdata_o;
  logic [4:0]    xmem_range_o;
  logic          mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
  logic [31:0]   mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]    mem_be_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  cv32e40p_xmem_data_arbiter #(
    .MAX_OUTSTANDING (2),
    .XMEM_RESP_DEPTH (2)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .core_req_i      (core_req_i),
    .core_gnt_o      (core_gnt_o),
    .core_addr_i     (core_addr_i),
    .core_wdata_i    (core_wdata_i),
    .core_we_i       (core_we_i),
    .core_be_i       (core_be_i),
    .core_rvalid_o   (core_rvalid_o),
    .core_rdata_o    (core_rdata_o),
    .xmem_valid_i    (xmem_valid_i),
    .xmem_ready_o    (xmem_ready_o),
    .xmem_laddr_i    (xmem_laddr_i),
    .xmem_wdata_i    (xmem_wdata_i),
    .xmem_width_i    (xmem_width_i),
    .xmem_req_type_i (xmem_req_type_i),
    .xmem_rvalid_o   (xmem_rvalid_o),
    .xmem_rready_i   (xmem_rready_i),
    .xmem_rdata_o    (xmem_rdata_o),
    .xmem_range_o    (xmem_range_o),
    .xmem_status_o   (xmem_status_o),
    .mem_req_o       (mem_req_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_addr_o      (mem_addr_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_we_o        (mem_we_o),
    .mem_be_o        (mem_be_o),
    .mem_rvalid_i    (mem_rvalid_i),
    .mem_rdata_i     (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs;
    core_req_i      = 1'b0;
    core_we_i       = 1'b0;
    core_addr_i     = '0;
    core_wdata_i    = '0;
    core_be_i       = 4'hF;
    xmem_valid_i    = 1'b0;
    xmem_rready_i   = 1'b1;
    xmem_laddr_i    = '0;
    xmem_wdata_i    = '0;
    xmem_width_i    = XMEM_W_WORD;
    xmem_req_type_i = READ;
    mem_gnt_i       = 1'b0;
    mem_rvalid_i    = 1'b0;
    mem_rdata_i     = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] o;
    do_reset();
    rst_i = 1'b1;
    core_req_i = 1'b1; xmem_valid_i = 1'b1; mem_gnt_i = 1'b1;
    #1;
    o = {mem_req_o, core_gnt_o, xmem_ready_o, core_rvalid_o, xmem_rvalid_o, xmem_status_o,
         mem_we_o, mem_be_o, xmem_range_o, 16'h0};
    vec_cnt++;
    if (o !== 32'h0) begin err_cnt++; $display("FAIL reset_ctrl got %h exp 0", o); end
    vec_cnt++;
    if ({mem_addr_o | mem_wdata_o | core_rdata_o | xmem_rdata_o} !== 32'h0) begin
      err_cnt++; $display("FAIL reset_data got %h/%h/%h/%h exp 0", mem_addr_o, mem_wdata_o, core_rdata_o, xmem_rdata_o);
    end
    tick();
    idle_inputs();
    rst_i = 1'b0;
  endtask

  task automatic test_core_single;
    do_reset();
    core_req_i = 1'b1; core_addr_i = 32'h100; core_be_i = 4'hF; mem_gnt_i = 1'b1;
    #1;
    vec_cnt++;
    if ({mem_req_o, core_gnt_o, xmem_ready_o} !== 3'b110) begin
      err_cnt++; $display("FAIL core_req got req/gnt/xrdy=%b exp 110", {mem_req_o, core_gnt_o, xmem_ready_o});
    end
    vec_cnt++;
    if (mem_addr_o !== 32'h100) begin err_cnt++; $display("FAIL core_addr got %h exp 00000100", mem_addr_o); end
    tick();
    core_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    #1;
    vec_cnt++;
    if (core_rvalid_o !== 1'b1 || core_rdata_o !== 32'hDEADBEEF) begin
      err_cnt++; $display("FAIL core_resp got v=%b d=%h exp v=1 d=deadbeef", core_rvalid_o, core_rdata_o);
    end
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    vec_cnt++;
    if ({xmem_rvalid_o, xmem_ready_o, core_rvalid_o} !== 3'b000 || xmem_rdata_o !== 32'h0) begin
      err_cnt++; $display("FAIL core_xmem_quiet got %b/%h exp 000/0", {xmem_rvalid_o, xmem_ready_o, core_rvalid_o}, xmem_rdata_o);
    end
  endtask

  task automatic test_round_robin;
    logic        req_on [6] = '{1, 1, 1, 1, 0, 0};
    logic        e_cg   [6] = '{1, 0, 1, 0, 0, 0};
    logic        e_xr   [6] = '{0, 1, 0, 1, 0, 0};
    logic [31:0] e_addr [6] = '{32'h1000, 32'h2000, 32'h1000, 32'h2000, 0, 0};
    logic        rv_in  [6] = '{0, 1, 1, 1, 1, 0};
    logic [31:0] rd_in  [6] = '{0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 0};
    logic        e_crv  [6] = '{0, 1, 0, 1, 0, 0};
    logic [31:0] e_crd  [6] = '{0, 32'h11111111, 0, 32'h33333333, 0, 0};
    logic        e_xrv  [6] = '{0, 0, 0, 1, 0, 1};
    logic [31:0] e_xrd  [6] = '{0, 0, 0, 32'h22222222, 0, 32'h44444444};
    do_reset();
    core_addr_i = 32'h1000; xmem_laddr_i = 32'h2000; mem_gnt_i = 1'b1; xmem_rready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      core_req_i = req_on[c]; xmem_valid_i = req_on[c];
      mem_rvalid_i = rv_in[c]; mem_rdata_i = rd_in[c];
      #1;
      vec_cnt++;
      if (core_gnt_o !== e_cg[c] || xmem_ready_o !== e_xr[c] || mem_addr_o !== e_addr[c]) begin
        err_cnt++; $display("FAIL rr_grant c%0d got cg=%b xr=%b a=%h exp cg=%b xr=%b a=%h",
                            c, core_gnt_o, xmem_ready_o, mem_addr_o, e_cg[c], e_xr[c], e_addr[c]);
      end
      vec_cnt++;
      if (core_rvalid_o !== e_crv[c] || core_rdata_o !== e_crd[c] ||
          xmem_rvalid_o !== e_xrv[c] || xmem_rdata_o !== e_xrd[c]) begin
        err_cnt++; $display("FAIL rr_resp c%0d got c=%b/%h x=%b/%h exp c=%b/%h x=%b/%h", c,
                            core_rvalid_o, core_rdata_o, xmem_rvalid_o, xmem_rdata_o,
                            e_crv[c], e_crd[c], e_xrv[c], e_xrd[c]);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_xmem_mapping;
    logic [31:0] la   [4] = '{32'h203, 32'h202, 32'h204, 32'h208};
    logic [31:0] wd   [4] = '{32'h000000A5, 32'h00001234, 32'hCAFEF00D, 32'h01020304};
    logic [2:0]  wdt  [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic        wr   [4] = '{1, 1, 0, 1};
    logic [31:0] e_a  [4] = '{32'h200, 32'h200, 32'h204, 32'h208};
    logic [3:0]  e_be [4] = '{4'b1000, 4'b1100, 4'b1111, 4'b1111};
    logic [31:0] e_wd [4] = '{32'hA5A5A5A5, 32'h12341234, 32'hCAFEF00D, 32'h01020304};
    do_reset();
    xmem_valid_i = 1'b1; mem_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      xmem_laddr_i = la[i]; xmem_wdata_i = wd[i]; xmem_width_i = wdt[i];
      xmem_req_type_i = wr[i] ? WRITE : READ;
      #1;
      vec_cnt++;
      if (mem_req_o !== 1'b1 || xmem_ready_o !== 1'b0 || mem_addr_o !== e_a[i] ||
          mem_be_o !== e_be[i] || mem_wdata_o !== e_wd[i] || mem_we_o !== wr[i]) begin
        err_cnt++; $display("FAIL xmap%0d got req=%b rdy=%b a=%h be=%b wd=%h we=%b exp 1 0 a=%h be=%b wd=%h we=%b",
                            i, mem_req_o, xmem_ready_o, mem_addr_o, mem_be_o, mem_wdata_o, mem_we_o,
                            e_a[i], e_be[i], e_wd[i], wr[i]);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_lock;
    do_reset();
    core_req_i = 1'b1; core_addr_i = 32'h300; xmem_laddr_i = 32'h400; mem_gnt_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c >= 1) xmem_valid_i = 1'b1;
      if (c == 3) mem_gnt_i = 1'b1;
      #1;
      vec_cnt++;
      if (mem_addr_o !== 32'h300 || core_gnt_o !== (c == 3) || xmem_ready_o !== 1'b0) begin
        err_cnt++; $display("FAIL lock_hold c%0d got a=%h cg=%b xr=%b exp a=00000300 cg=%b xr=0",
                            c, mem_addr_o, core_gnt_o, xmem_ready_o, (c == 3));
      end
      tick();
    end
    core_req_i = 1'b0;
    #1;
    vec_cnt++;
    if (mem_addr_o !== 32'h400 || xmem_ready_o !== 1'b1 || core_gnt_o !== 1'b0) begin
      err_cnt++; $display("FAIL lock_next got a=%h xr=%b cg=%b exp a=00000400 xr=1 cg=0", mem_addr_o, xmem_ready_o, core_gnt_o);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_backpressure;
    logic        xv    [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
    logic [31:0] xa    [8] = '{32'h500, 32'h504, 32'h508, 32'h508, 32'h508, 0, 0, 0};
    logic        cr    [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
    logic        rv    [8] = '{0, 1, 1, 0, 1, 0, 0, 0};
    logic [31:0] rd    [8] = '{0, 32'hAAAA0001, 32'hBBBB0002, 0, 32'h66666666, 0, 0, 0};
    logic        rr    [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
    logic        e_req [8] = '{1, 1, 0, 1, 0, 0, 0, 0};
    logic        e_xr  [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
    logic        e_cg  [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
    logic [31:0] e_a   [8] = '{32'h500, 32'h504, 0, 32'h600, 0, 0, 0, 0};
    logic        e_crv [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    logic        e_xrv [8] = '{0, 0, 1, 1, 1, 1, 1, 0};
    logic [31:0] e_xrd [8] = '{0, 0, 32'hAAAA0001, 32'hAAAA0001, 32'hAAAA0001, 32'hAAAA0001, 32'hBBBB0002, 0};
    do_reset();
    core_addr_i = 32'h600; mem_gnt_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      xmem_valid_i = xv[c]; xmem_laddr_i = xa[c]; core_req_i = cr[c];
      mem_rvalid_i = rv[c]; mem_rdata_i = rd[c]; xmem_rready_i = rr[c];
      #1;
      vec_cnt++;
      if (mem_req_o !== e_req[c] || xmem_ready_o !== e_xr[c] || core_gnt_o !== e_cg[c] || mem_addr_o !== e_a[c]) begin
        err_cnt++; $display("FAIL bp_req c%0d got req=%b xr=%b cg=%b a=%h exp req=%b xr=%b cg=%b a=%h", c,
                            mem_req_o, xmem_ready_o, core_gnt_o, mem_addr_o, e_req[c], e_xr[c], e_cg[c], e_a[c]);
      end
      vec_cnt++;
      if (core_rvalid_o !== e_crv[c] || (e_crv[c] && core_rdata_o !== 32'h66666666) ||
          xmem_rvalid_o !== e_xrv[c] || xmem_rdata_o !== e_xrd[c]) begin
        err_cnt++; $display("FAIL bp_resp c%0d got crv=%b crd=%h xrv=%b xrd=%h exp crv=%b xrv=%b xrd=%h", c,
                            core_rvalid_o, core_rdata_o, xmem_rvalid_o, xmem_rdata_o, e_crv[c], e_xrv[c], e_xrd[c]);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_midop;
    do_reset();
    xmem_valid_i = 1'b1; xmem_laddr_i = 32'h700; mem_gnt_i = 1'b1;
    tick();
    xmem_valid_i = 1'b0; core_req_i = 1'b1; core_addr_i = 32'h800; mem_gnt_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    #1;
    vec_cnt++;
    if ({mem_req_o, core_gnt_o, xmem_ready_o, core_rvalid_o, xmem_rvalid_o} !== 5'b0 || mem_addr_o !== 32'h0) begin
      err_cnt++; $display("FAIL midrst_out got %b a=%h exp 00000 a=0",
                          {mem_req_o, core_gnt_o, xmem_ready_o, core_rvalid_o, xmem_rvalid_o}, mem_addr_o);
    end
    tick();
    rst_i = 1'b0;
    core_addr_i = 32'h900; mem_gnt_i = 1'b1;
    #1;
    vec_cnt++;
    if (core_gnt_o !== 1'b1 || mem_addr_o !== 32'h900) begin
      err_cnt++; $display("FAIL midrst_gnt got cg=%b a=%h exp cg=1 a=00000900", core_gnt_o, mem_addr_o);
    end
    tick();
    core_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h12345678;
    #1;
    vec_cnt++;
    if (core_rvalid_o !== 1'b1 || core_rdata_o !== 32'h12345678) begin
      err_cnt++; $display("FAIL midrst_route got v=%b d=%h exp v=1 d=12345678", core_rvalid_o, core_rdata_o);
    end
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    vec_cnt++;
    if (xmem_rvalid_o !== 1'b0) begin err_cnt++; $display("FAIL midrst_xq got %b exp 0", xmem_rvalid_o); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    test_reset();
    test_core_single();
    test_round_robin();
    test_xmem_mapping();
    test_lock();
    test_backpressure();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
